// File: rtl/blockmem_sdp_pipe.sv
// Simple-dual-port block memory with a 1..4 stage read pipeline, byte enables and defined read-during-write.
// Optional macro BLOCKMEM_SDP_CLEAR_EN adds a post-reset clear sequencer that zeroes the array.
module blockmem_sdp_pipe #(
    parameter int    G_DATAWIDTH = 32,
    parameter int    G_MEMDEPTH  = 1024,
    parameter int    G_BWENABLE  = 0,
    parameter int    G_RDLATENCY = 1,
    parameter int    G_RDW_MODE  = 0,
    parameter string G_INIT_FILE = "",
    parameter int    G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    parameter int    G_PADWIDTH  = (G_DATAWIDTH + 7) & ~7,
    parameter int    G_WEWIDTH   = (((G_PADWIDTH - 1) / 8) * G_BWENABLE) + 1
) (
    input  logic                   clka,
    input  logic                   resetn,
    output logic                   busy,
    input  logic                   wen,
    input  logic [G_WEWIDTH-1:0]   wbe,
    input  logic [G_ADDRWIDTH-1:0] waddr,
    input  logic [G_DATAWIDTH-1:0] wdata,
    input  logic                   ren,
    input  logic [G_ADDRWIDTH-1:0] raddr,
    output logic [G_DATAWIDTH-1:0] rdata,
    output logic                   rvalid
);

    localparam int                     L_NBYTES = G_PADWIDTH / 8;
    localparam logic [G_ADDRWIDTH:0]   L_DEPTH  = (G_ADDRWIDTH + 1)'(G_MEMDEPTH);

    if (G_RDLATENCY < 1 || G_RDLATENCY > 4) begin : g_bad_latency
        $error("blockmem_sdp_pipe: G_RDLATENCY must be in 1..4");
    end

    logic [G_PADWIDTH-1:0]  r_mem [G_MEMDEPTH];
    logic [L_NBYTES-1:0]    w_bmask;
    logic [G_PADWIDTH-1:0]  w_wdata_pad;
    logic [G_PADWIDTH-1:0]  w_rd_word;
    logic                   w_waddr_ok;
    logic                   w_raddr_ok;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_clr_we;
    logic [G_ADDRWIDTH-1:0] w_clr_addr;

    if (G_BWENABLE != 0) begin : g_bw
        assign w_bmask = wbe;
    end else begin : g_word
        assign w_bmask = {L_NBYTES{wbe[0]}};
    end

    always_comb begin
        w_wdata_pad                   = '0;
        w_wdata_pad[G_DATAWIDTH-1:0]  = wdata;
    end

    // Requests are only accepted while not busy; an accepted read yields exactly one rvalid pulse.
    assign w_waddr_ok = {1'b0, waddr} < L_DEPTH;
    assign w_raddr_ok = {1'b0, raddr} < L_DEPTH;
    assign w_wr_acc   = wen && !busy && w_waddr_ok;
    assign w_rd_acc   = ren && !busy;

`ifdef BLOCKMEM_SDP_CLEAR_EN
    localparam logic [G_ADDRWIDTH-1:0] L_LAST = G_ADDRWIDTH'(G_MEMDEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [G_ADDRWIDTH-1:0] r_clr_addr;
    logic [G_ADDRWIDTH-1:0] w_clr_addr_nxt;

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        busy           = 1'b0;
        case (r_state)
            S_CLEAR: begin
                busy     = 1'b1;
                w_clr_we = 1'b1;
                if (r_clr_addr == L_LAST) w_state_nxt = S_READY;
                else                      w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
            default: ;
        endcase
    end

    assign w_clr_addr = r_clr_addr;
`else
    assign busy       = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    always_ff @(posedge clka) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            for (int b = 0; b < L_NBYTES; b++) begin
                if (w_bmask[b]) r_mem[waddr][b*8 +: 8] <= w_wdata_pad[b*8 +: 8];
            end
        end
    end

    // Same-address forwarding merges enabled write bytes over the stored word.
    always_comb begin
        w_rd_word = '0;
        if (w_raddr_ok) begin
            w_rd_word = r_mem[raddr];
            if (G_RDW_MODE != 0 && w_wr_acc && waddr == raddr) begin
                for (int b = 0; b < L_NBYTES; b++) begin
                    if (w_bmask[b]) w_rd_word[b*8 +: 8] = w_wdata_pad[b*8 +: 8];
                end
            end
        end
    end

    logic [G_DATAWIDTH-1:0] r_pipe_data [G_RDLATENCY];
    logic [G_RDLATENCY-1:0] r_pipe_vld;

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < G_RDLATENCY; i++) r_pipe_data[i] <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) r_pipe_data[0] <= w_rd_word[G_DATAWIDTH-1:0];
            for (int i = 1; i < G_RDLATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign rvalid = r_pipe_vld[G_RDLATENCY-1];
    assign rdata  = r_pipe_data[G_RDLATENCY-1];

endmodule

// File: tb/tb_blockmem_sdp_pipe.sv
// Bench for blockmem_sdp_pipe: two instances (byte-enable/latency-3/forwarding and word/latency-1/old-data)
// driven in lockstep and compared against a queue-based memory model.
module tb_blockmem_sdp_pipe;

    localparam int DEPTH = 100;
    localparam int AW    = 7;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [3:0]    wbe   = '0;
    logic          wbe_b = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [31:0]   wdata = '0;
    logic          busy_a, busy_b, rvalid_a, rvalid_b;
    logic [31:0]   rdata_a, rdata_b;

    always #5 clk = ~clk;

    blockmem_sdp_pipe #(
        .G_DATAWIDTH(32), .G_MEMDEPTH(DEPTH), .G_BWENABLE(1), .G_RDLATENCY(LAT_A), .G_RDW_MODE(1)
    ) dut_a (
        .clka(clk), .resetn(rst_n), .busy(busy_a), .wen(wen), .wbe(wbe), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
    );

    blockmem_sdp_pipe #(
        .G_DATAWIDTH(32), .G_MEMDEPTH(DEPTH), .G_BWENABLE(0), .G_RDLATENCY(LAT_B), .G_RDW_MODE(0)
    ) dut_b (
        .clka(clk), .resetn(rst_n), .busy(busy_b), .wen(wen), .wbe(wbe_b), .waddr(waddr),
        .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    // Reference model: word arrays plus a latency delay line of {valid, data} per instance.
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic [32:0] exp_q_a[$];
    logic [32:0] exp_q_b[$];
    logic [31:0] last_a, last_b, ed_a, ed_b;
    logic        ev_a, ev_b;
    int          busy_left;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset_state();
        exp_q_a.delete();
        exp_q_b.delete();
        for (int i = 0; i < LAT_A - 1; i++) exp_q_a.push_back('0);
        for (int i = 0; i < LAT_B - 1; i++) exp_q_b.push_back('0);
        last_a = '0;
        last_b = '0;
        ev_a   = 1'b0;
        ev_b   = 1'b0;
        ed_a   = '0;
        ed_b   = '0;
`ifdef BLOCKMEM_SDP_CLEAR_EN
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
`else
        busy_left = 0;
`endif
    endtask

    task automatic do_reset(input int cycles);
        wen   = 1'b0;
        ren   = 1'b0;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset_state();
    endtask

    // Drives one cycle, advances the model, and leaves the expected outputs in ev_*/ed_*.
    task automatic step(input logic we, input logic [3:0] be, input logic be_b, input logic [AW-1:0] wa,
                        input logic [31:0] wd, input logic re, input logic [AW-1:0] ra);
        logic        bsy, wa_ok, ra_ok;
        logic [31:0] va, vb;
        logic [32:0] ea, eb;
        wen = we; wbe = be; wbe_b = be_b; waddr = wa; wdata = wd; ren = re; raddr = ra;
        bsy   = (busy_left > 0);
        wa_ok = int'(wa) < DEPTH;
        ra_ok = int'(ra) < DEPTH;
        va = '0;
        vb = '0;
        if (ra_ok) begin
            va = (we && wa_ok && wa == ra) ? merge(mem_a[ra], wd, be) : mem_a[ra];
            vb = mem_b[ra];
        end
        exp_q_a.push_back((re && !bsy) ? {1'b1, va} : 33'd0);
        exp_q_b.push_back((re && !bsy) ? {1'b1, vb} : 33'd0);
        if (we && !bsy && wa_ok) begin
            mem_a[wa] = merge(mem_a[wa], wd, be);
            mem_b[wa] = merge(mem_b[wa], wd, {4{be_b}});
        end
        if (busy_left > 0) busy_left--;
        @(posedge clk);
        #1;
        ea = exp_q_a.pop_front();
        eb = exp_q_b.pop_front();
        if (ea[32]) last_a = ea[31:0];
        if (eb[32]) last_b = eb[31:0];
        ev_a = ea[32]; ed_a = last_a;
        ev_b = eb[32]; ed_b = last_b;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        wen = 1'b0; ren = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if ({rvalid_a, rdata_a} !== 33'd0) $display("FAIL reset_a: got v=%0b d=%h, expected v=0 d=0", rvalid_a, rdata_a);
        else n_pass++;
        n_checks++;
        if ({rvalid_b, rdata_b} !== 33'd0) $display("FAIL reset_b: got v=%0b d=%h, expected v=0 d=0", rvalid_b, rdata_b);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        model_reset_state();
`ifndef BLOCKMEM_SDP_CLEAR_EN
        n_checks++;
        if ({busy_a, busy_b} !== 2'b00) $display("FAIL reset_busy: got %b%b, expected 00", busy_a, busy_b);
        else n_pass++;
`endif
    endtask

`ifdef BLOCKMEM_SDP_CLEAR_EN
    task automatic test_clear();
        int cnt;
        for (int pass = 0; pass < 2; pass++) begin
            cnt = 0;
            if (pass == 1) begin
                repeat (7) idle();
                do_reset(2);
            end else begin
                do_reset(2);
            end
            for (int k = 0; k < 300 && busy_a === 1'b1; k++) begin
                cnt++;
                step(1'b1, 4'hF, 1'b1, AW'(k % DEPTH), 32'hFFFF_FFFF, 1'b1, AW'(k % DEPTH));
                n_checks++;
                if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0)
                    $display("FAIL clear_ren_dropped: got va=%0b vb=%0b, expected 0 0", rvalid_a, rvalid_b);
                else n_pass++;
            end
            n_checks++;
            if (cnt != DEPTH) $display("FAIL clear_busy_len: got %0d cycles, expected %0d", cnt, DEPTH);
            else n_pass++;
        end
        for (int k = 0; k < DEPTH + LAT_A; k++) begin
            if (k < DEPTH) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(k));
            else idle();
            n_checks++;
            if ({rvalid_a, rdata_a} !== {ev_a, ed_a})
                $display("FAIL clear_zero_a: got v=%0b d=%h, expected v=%0b d=%h", rvalid_a, rdata_a, ev_a, ed_a);
            else n_pass++;
            n_checks++;
            if (rvalid_b === 1'b1 && rdata_b !== 32'd0)
                $display("FAIL clear_zero_b: got d=%h, expected 0", rdata_b);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b1, 4'hF, 1'b1, AW'(a), $urandom, 1'b0, '0);
            n_checks++;
            if (rvalid_a !== ev_a || rvalid_b !== ev_b)
                $display("FAIL fill: got va=%0b vb=%0b, expected va=%0b vb=%0b", rvalid_a, rvalid_b, ev_a, ev_b);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        step(1'b1, 4'hF, 1'b1, AW'(16), 32'hDEADBEEF, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(16));
            else idle();
            n_checks++;
            if ({rvalid_a, rdata_a} !== {ev_a, ed_a} || {rvalid_b, rdata_b} !== {ev_b, ed_b})
                $display("FAIL wr_rd_model: got a=%0b/%h b=%0b/%h, expected a=%0b/%h b=%0b/%h",
                         rvalid_a, rdata_a, rvalid_b, rdata_b, ev_a, ed_a, ev_b, ed_b);
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if ({rvalid_b, rdata_b} !== {1'b1, 32'hDEADBEEF})
                    $display("FAIL wr_rd_lat1: got v=%0b d=%h, expected v=1 d=deadbeef", rvalid_b, rdata_b);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({rvalid_a, rdata_a} !== {1'b1, 32'hDEADBEEF})
                    $display("FAIL wr_rd_lat3: got v=%0b d=%h, expected v=1 d=deadbeef", rvalid_a, rdata_a);
                else n_pass++;
            end
            if (k == 3) begin
                n_checks++;
                if ({rvalid_a, rdata_a} !== {1'b0, 32'hDEADBEEF})
                    $display("FAIL wr_rd_hold: got v=%0b d=%h, expected v=0 d=deadbeef", rvalid_a, rdata_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_byte_enable();
        step(1'b1, 4'hF, 1'b1, AW'(5), 32'h11223344, 1'b0, '0);
        step(1'b1, 4'b0101, 1'b0, AW'(5), 32'hAABBCCDD, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(5));
            else idle();
            if (k == 0) begin
                n_checks++;
                if ({rvalid_b, rdata_b} !== {1'b1, 32'h11223344})
                    $display("FAIL be_word_gate: got v=%0b d=%h, expected v=1 d=11223344", rvalid_b, rdata_b);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({rvalid_a, rdata_a} !== {1'b1, 32'h11BB33DD})
                    $display("FAIL be_bytes: got v=%0b d=%h, expected v=1 d=11bb33dd", rvalid_a, rdata_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 8; a++) step(1'b1, 4'hF, 1'b1, AW'(a), 32'(a * 3), 1'b0, '0);
        for (int k = 0; k < 11; k++) begin
            if (k < 8) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(k));
            else idle();
            n_checks++;
            if (k >= 2 && k <= 9) begin
                if ({rvalid_a, rdata_a} !== {1'b1, 32'((k - 2) * 3)})
                    $display("FAIL b2b_a[%0d]: got v=%0b d=%h, expected v=1 d=%h", k, rvalid_a, rdata_a, 32'((k - 2) * 3));
                else n_pass++;
            end else if (rvalid_a !== 1'b0) begin
                $display("FAIL b2b_a_gap[%0d]: got v=%0b, expected v=0", k, rvalid_a);
            end else n_pass++;
            n_checks++;
            if ({rvalid_b, rdata_b} !== {ev_b, ed_b})
                $display("FAIL b2b_b[%0d]: got v=%0b d=%h, expected v=%0b d=%h", k, rvalid_b, rdata_b, ev_b, ed_b);
            else n_pass++;
        end
    endtask

    task automatic test_rdw();
        step(1'b1, 4'hF, 1'b1, AW'(9), 32'hAA, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) step(1'b1, 4'hF, 1'b1, AW'(9), 32'h55, 1'b1, AW'(9));
            else idle();
            if (k == 0) begin
                n_checks++;
                if ({rvalid_b, rdata_b} !== {1'b1, 32'hAA})
                    $display("FAIL rdw_old: got v=%0b d=%h, expected v=1 d=aa", rvalid_b, rdata_b);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({rvalid_a, rdata_a} !== {1'b1, 32'h55})
                    $display("FAIL rdw_new: got v=%0b d=%h, expected v=1 d=55", rvalid_a, rdata_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_out_of_range();
        step(1'b1, 4'hF, 1'b1, AW'(100), 32'h1234, 1'b0, '0);
        step(1'b1, 4'hF, 1'b1, AW'(127), 32'hFFFF, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(100));
            else if (k == 1) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(99));
            else idle();
            n_checks++;
            if ({rvalid_a, rdata_a} !== {ev_a, ed_a} || {rvalid_b, rdata_b} !== {ev_b, ed_b})
                $display("FAIL oor_model[%0d]: got a=%0b/%h b=%0b/%h, expected a=%0b/%h b=%0b/%h", k,
                         rvalid_a, rdata_a, rvalid_b, rdata_b, ev_a, ed_a, ev_b, ed_b);
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if ({rvalid_b, rdata_b} !== {1'b1, 32'd0})
                    $display("FAIL oor_read_b: got v=%0b d=%h, expected v=1 d=0", rvalid_b, rdata_b);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if ({rvalid_a, rdata_a} !== {1'b1, 32'd0})
                    $display("FAIL oor_read_a: got v=%0b d=%h, expected v=1 d=0", rvalid_a, rdata_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa, ra;
        for (int k = 0; k < 400; k++) begin
            wa = AW'($urandom_range(0, 110));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 110));
            step(1'($urandom), 4'($urandom), 1'($urandom), wa, $urandom, 1'($urandom_range(0, 3) != 0), ra);
            n_checks++;
            if ({rvalid_a, rdata_a} !== {ev_a, ed_a})
                $display("FAIL rand_a[%0d]: got v=%0b d=%h, expected v=%0b d=%h", k, rvalid_a, rdata_a, ev_a, ed_a);
            else n_pass++;
            n_checks++;
            if ({rvalid_b, rdata_b} !== {ev_b, ed_b})
                $display("FAIL rand_b[%0d]: got v=%0b d=%h, expected v=%0b d=%h", k, rvalid_b, rdata_b, ev_b, ed_b);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, AW'(16));
        wen = 1'b0; ren = 1'b1; raddr = AW'(5);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== 66'd0)
            $display("FAIL midflight_async: got a=%0b/%h b=%0b/%h, expected all 0", rvalid_a, rdata_a, rvalid_b, rdata_b);
        else n_pass++;
        do_reset(2);
        for (int k = 0; k < LAT_A + 1; k++) begin
            idle();
            n_checks++;
            if ({rvalid_a, rdata_a, rvalid_b, rdata_b} !== 66'd0)
                $display("FAIL midflight_drop[%0d]: got a=%0b/%h b=%0b/%h, expected all 0", k,
                         rvalid_a, rdata_a, rvalid_b, rdata_b);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
`ifdef BLOCKMEM_SDP_CLEAR_EN
        test_clear();
`endif
        test_fill();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_rdw();
        test_out_of_range();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
